// File: rtl/ps_seq_if.sv
// ps_seq_if: decoder, ureg and sequencer-status bundle around ps_seq_core
interface ps_seq_if #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int PW = 3
);
  logic          dcd_jmp;
  logic          dcd_call;
  logic          dcd_rtn;
  logic          dcd_idle;
  logic [AW-1:0] dcd_tgt;
  logic          wake;
  logic          ur_wrt_en;
  logic [4:0]    ur_wrt_add;
  logic [DW-1:0] ur_wrt_dt;
  logic [4:0]    ur_rd_add;
  logic [DW-1:0] ur_rd_dt;
  logic [AW-1:0] ps_pm_add;
  logic          ps_pm_cslt;
  logic [AW-1:0] ps_daddr;
  logic [AW-1:0] ps_pc;
  logic          ps_e_vld;
  logic          ps_flush;
  logic          ps_idle;
  logic [3:0]    ps_stcky;
  logic [PW-1:0] ps_stck_cnt;
  modport master (
    output dcd_jmp, dcd_call, dcd_rtn, dcd_idle, dcd_tgt, wake,
    output ur_wrt_en, ur_wrt_add, ur_wrt_dt, ur_rd_add,
    input  ur_rd_dt, ps_pm_add, ps_pm_cslt, ps_daddr, ps_pc, ps_e_vld,
    input  ps_flush, ps_idle, ps_stcky, ps_stck_cnt
  );
  modport slave (
    input  dcd_jmp, dcd_call, dcd_rtn, dcd_idle, dcd_tgt, wake,
    input  ur_wrt_en, ur_wrt_add, ur_wrt_dt, ur_rd_add,
    output ur_rd_dt, ps_pm_add, ps_pm_cslt, ps_daddr, ps_pc, ps_e_vld,
    output ps_flush, ps_idle, ps_stcky, ps_stck_cnt
  );
endinterface

// File: rtl/ps_seq_core.sv
// ps_seq_core: F/D/E address pipeline with redirects, idle/wake and a counting PC stack
module ps_seq_core #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int PW    = 3
) (
  input logic   clk,
  input logic   rst,
  ps_seq_if.slave bus
);
  typedef enum logic {RUN, IDLE} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] faddr_q, faddr_d, daddr_q, daddr_d, pc_q, pc_d;
  logic          f_vld_q, f_vld_d, d_vld_q, d_vld_d, e_vld_q, e_vld_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic [AW-1:0] stk_q [DEPTH];
  logic [AW-1:0] stk_d [DEPTH];
  logic          empty, full, idle_tk, rtn_tk, rtn_nop, call_tk, jmp_tk;
  logic          redir, hold, push, top_wr, st_wr;
  logic [AW-1:0] top, tgt;
  logic [DW-1:0] rd_val;
  // decode the E-stage instruction by priority idle > rtn > call > jmp
  always_comb begin
    empty   = cnt_q == '0;
    full    = cnt_q == PW'(DEPTH);
    idle_tk = e_vld_q & bus.dcd_idle;
    rtn_tk  = e_vld_q & !bus.dcd_idle & bus.dcd_rtn & !empty;
    rtn_nop = e_vld_q & !bus.dcd_idle & bus.dcd_rtn & empty;
    call_tk = e_vld_q & !bus.dcd_idle & !bus.dcd_rtn & bus.dcd_call;
    jmp_tk  = e_vld_q & !bus.dcd_idle & !bus.dcd_rtn & !bus.dcd_call & bus.dcd_jmp;
    redir   = rtn_tk | call_tk | jmp_tk;
    hold    = (state_q == IDLE) | idle_tk;
    push    = call_tk & !full;
    top     = '0;
    for (int i = 0; i < DEPTH; i++) top = (cnt_q == PW'(i + 1)) ? stk_q[i] : top;
    tgt     = rtn_tk ? top : bus.dcd_tgt;
    top_wr  = bus.ur_wrt_en & (bus.ur_wrt_add == 5'h04) & !empty & !call_tk & !rtn_tk;
    st_wr   = bus.ur_wrt_en & (bus.ur_wrt_add == 5'h1e);
  end
  // idle/run state machine: next state
  always_comb begin
    state_d = (state_q == RUN) ? (idle_tk ? IDLE : RUN) : (bus.wake ? RUN : IDLE);
  end
  // pipeline advance, stack update and sticky flags
  always_comb begin
    faddr_d = hold ? faddr_q : redir ? tgt : faddr_q + AW'(1);
    daddr_d = hold ? daddr_q : faddr_q;
    pc_d    = hold ? pc_q : daddr_q;
    f_vld_d = state_d == RUN;
    d_vld_d = !hold & !redir & f_vld_q;
    e_vld_d = !hold & !redir & d_vld_q;
    cnt_d   = push ? cnt_q + PW'(1) : rtn_tk ? cnt_q - PW'(1) : cnt_q;
    ovf_d   = (call_tk & full) | (ovf_q & !(st_wr & bus.ur_wrt_dt[2]));
    unf_d   = rtn_nop | (unf_q & !(st_wr & bus.ur_wrt_dt[3]));
    stk_d   = stk_q;
    for (int i = 0; i < DEPTH; i++) begin
      stk_d[i] = (push && cnt_q == PW'(i)) ? pc_q + AW'(1) : stk_d[i];
      stk_d[i] = (top_wr && cnt_q == PW'(i + 1)) ? bus.ur_wrt_dt[AW-1:0] : stk_d[i];
    end
  end
  // idle/run state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end
  // address pipeline and stack registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      faddr_q <= '0;
      daddr_q <= '0;
      pc_q    <= '0;
      f_vld_q <= 1'b0;
      d_vld_q <= 1'b0;
      e_vld_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      stk_q   <= '{default: '0};
    end else begin
      faddr_q <= faddr_d;
      daddr_q <= daddr_d;
      pc_q    <= pc_d;
      f_vld_q <= f_vld_d;
      d_vld_q <= d_vld_d;
      e_vld_q <= e_vld_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      stk_q   <= stk_d;
    end
  end
  // ureg read mux with same-cycle bypass of writable registers
  always_comb begin
    rd_val = (bus.ur_rd_add == 5'h00) ? DW'(faddr_q) :
             (bus.ur_rd_add == 5'h01) ? DW'(daddr_q) :
             (bus.ur_rd_add == 5'h03) ? DW'(pc_q) :
             (bus.ur_rd_add == 5'h04) ? DW'(top) :
             (bus.ur_rd_add == 5'h05) ? DW'(cnt_q) :
             (bus.ur_rd_add == 5'h1e) ? DW'({unf_q, ovf_q, full, empty}) : '0;
    bus.ur_rd_dt = (bus.ur_wrt_en && bus.ur_wrt_add == bus.ur_rd_add &&
                    (bus.ur_rd_add == 5'h04 || bus.ur_rd_add == 5'h1e)) ? bus.ur_wrt_dt : rd_val;
  end
  assign bus.ps_pm_add   = faddr_q;
  assign bus.ps_pm_cslt  = state_q == RUN;
  assign bus.ps_daddr    = daddr_q;
  assign bus.ps_pc       = pc_q;
  assign bus.ps_e_vld    = e_vld_q;
  assign bus.ps_flush    = redir;
  assign bus.ps_idle     = state_q == IDLE;
  assign bus.ps_stcky    = {unf_q, ovf_q, full, empty};
  assign bus.ps_stck_cnt = cnt_q;
endmodule

// File: tb/tb_ps_seq_core.sv
// tb_ps_seq_core: table-driven ureg vectors plus scoreboarded redirect/idle/reset sequences
module tb_ps_seq_core;
  localparam int AW = 16, DW = 16, DEPTH = 4, PW = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] sb[$];
  typedef struct {
    logic        wen;
    logic [4:0]  wadd;
    logic [15:0] wdt;
    logic [4:0]  radd;
    logic [15:0] exp;
  } vec_t;
  vec_t vt[13];
  ps_seq_if #(.AW(AW), .DW(DW), .PW(PW)) bus();
  ps_seq_core #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .PW(PW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask
  task automatic clr_dcd();
    bus.dcd_jmp = 0; bus.dcd_call = 0; bus.dcd_rtn = 0; bus.dcd_idle = 0; bus.dcd_tgt = '0;
  endtask
  task automatic wait_ev();
    int b = 0;
    while (!bus.ps_e_vld && b < 10) begin tick(); b++; end
    if (!bus.ps_e_vld) begin
      n_chk++; n_err++;
      $display("FAIL wait_ev: e_vld=%0b after %0d cycles, required 1", bus.ps_e_vld, b);
    end
  endtask
  task automatic pop_pc(input string nm);
    wait_ev();
    if (sb.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL %s: scoreboard empty, got pc %0h", nm, bus.ps_pc);
    end else chk(nm, bus.ps_pc, sb.pop_front());
  endtask
  task automatic issue(input string nm, input logic j, input logic c, input logic r,
                       input logic [AW-1:0] t, input logic fl, input logic [AW-1:0] exp_tgt);
    wait_ev();
    bus.dcd_jmp = j; bus.dcd_call = c; bus.dcd_rtn = r; bus.dcd_tgt = t;
    #1 chk({nm, "_flush"}, bus.ps_flush, fl);
    if (fl) sb.push_back(exp_tgt);
    tick();
    clr_dcd();
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_pm_add"}, bus.ps_pm_add, 0);
    chk({nm, "_daddr"}, bus.ps_daddr, 0);
    chk({nm, "_pc"}, bus.ps_pc, 0);
    chk({nm, "_e_vld"}, bus.ps_e_vld, 0);
    chk({nm, "_flush"}, bus.ps_flush, 0);
    chk({nm, "_idle"}, bus.ps_idle, 0);
    chk({nm, "_cslt"}, bus.ps_pm_cslt, 1);
    chk({nm, "_stcky"}, bus.ps_stcky, 4'b0001);
    chk({nm, "_cnt"}, bus.ps_stck_cnt, 0);
  endtask
  initial begin
    int b;
    clr_dcd();
    bus.wake = 0; bus.ur_wrt_en = 0; bus.ur_wrt_add = '0; bus.ur_wrt_dt = '0; bus.ur_rd_add = '0;
    vt[0]  = '{1'b0, 5'h00, 16'h0000, 5'h00, 16'h0022};
    vt[1]  = '{1'b0, 5'h00, 16'h0000, 5'h01, 16'h0021};
    vt[2]  = '{1'b0, 5'h00, 16'h0000, 5'h03, 16'h0020};
    vt[3]  = '{1'b0, 5'h00, 16'h0000, 5'h02, 16'h0000};
    vt[4]  = '{1'b0, 5'h00, 16'h0000, 5'h04, 16'h0000};
    vt[5]  = '{1'b0, 5'h00, 16'h0000, 5'h05, 16'h0000};
    vt[6]  = '{1'b0, 5'h00, 16'h0000, 5'h1e, 16'h0001};
    vt[7]  = '{1'b1, 5'h00, 16'hffff, 5'h00, 16'h0022};
    vt[8]  = '{1'b1, 5'h04, 16'habcd, 5'h04, 16'habcd};
    vt[9]  = '{1'b0, 5'h00, 16'h0000, 5'h04, 16'h0000};
    vt[10] = '{1'b1, 5'h1e, 16'h000f, 5'h05, 16'h0000};
    vt[11] = '{1'b0, 5'h00, 16'h0000, 5'h1e, 16'h0001};
    vt[12] = '{1'b1, 5'h05, 16'h0007, 5'h1f, 16'h0000};
    #12;
    chk_reset("rst");
    rst = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("boot_pm_add%0d", k), bus.ps_pm_add, k);
      chk($sformatf("boot_e_vld%0d", k), bus.ps_e_vld, k == 3);
    end
    chk("boot_pc", bus.ps_pc, 1);
    b = 0;
    while (!(bus.ps_e_vld && bus.ps_pc == 5) && b < 20) begin tick(); b++; end
    chk("pc5_reached", bus.ps_pc, 5);
    issue("jmp40", 1, 0, 0, 16'h0040, 1, 16'h0040);
    chk("jmp_pm_add", bus.ps_pm_add, 16'h0040);
    chk("jmp_bubble1", bus.ps_e_vld, 0);
    bus.dcd_jmp = 1; bus.dcd_tgt = 16'h0099;
    #1 chk("bubble_jmp_ignored", bus.ps_flush, 0);
    tick();
    clr_dcd();
    chk("bubble_pm_add", bus.ps_pm_add, 16'h0041);
    chk("jmp_bubble2", bus.ps_e_vld, 0);
    pop_pc("jmp40_pc");
    issue("jmp10", 1, 0, 0, 16'h0010, 1, 16'h0010);
    pop_pc("jmp10_pc");
    for (int i = 0; i < 5; i++) begin
      issue($sformatf("call%0d", i), 0, 1, 0, 16'h0010, 1, 16'h0010);
      pop_pc($sformatf("call%0d_pc", i));
    end
    chk("full_cnt", bus.ps_stck_cnt, 4);
    chk("full_stcky", bus.ps_stcky, 4'b0110);
    bus.ur_rd_add = 5'h04;
    #1 chk("full_top", bus.ur_rd_dt, 16'h0011);
    for (int i = 0; i < 2; i++) begin
      issue($sformatf("rtn%0d", i), 0, 0, 1, 16'h0000, 1, 16'h0011);
      pop_pc($sformatf("rtn%0d_pc", i));
    end
    chk("rtn2_cnt", bus.ps_stck_cnt, 2);
    bus.ur_wrt_en = 1; bus.ur_wrt_add = 5'h04; bus.ur_wrt_dt = 16'h1234; bus.ur_rd_add = 5'h04;
    #1 chk("top_bypass", bus.ur_rd_dt, 16'h1234);
    tick();
    bus.ur_wrt_en = 0;
    #1 chk("top_stored", bus.ur_rd_dt, 16'h1234);
    chk("top_wr_cnt", bus.ps_stck_cnt, 2);
    issue("rtn2", 0, 0, 1, 16'h0000, 1, 16'h1234);
    pop_pc("rtn2_pc");
    issue("rtn3", 0, 0, 1, 16'h0000, 1, 16'h0011);
    pop_pc("rtn3_pc");
    chk("empty_stcky", bus.ps_stcky, 4'b0101);
    issue("rtn_empty", 0, 0, 1, 16'h0000, 0, 16'h0000);
    chk("rtn_empty_no_bubble", bus.ps_e_vld, 1);
    chk("unf_stcky", bus.ps_stcky, 4'b1101);
    bus.ur_wrt_en = 1; bus.ur_wrt_add = 5'h1e; bus.ur_wrt_dt = 16'h000c;
    tick();
    bus.ur_wrt_en = 0;
    chk("clr_stcky", bus.ps_stcky, 4'b0001);
    issue("jmp20", 1, 0, 0, 16'h0020, 1, 16'h0020);
    pop_pc("jmp20_pc");
    bus.dcd_idle = 1;
    tick();
    clr_dcd();
    chk("idle_set", bus.ps_idle, 1);
    chk("idle_cslt", bus.ps_pm_cslt, 0);
    chk("idle_e_vld", bus.ps_e_vld, 0);
    for (int i = 0; i < 10; i++) begin
      bus.dcd_jmp = 1; bus.dcd_tgt = 16'h0055;
      #1 chk($sformatf("idle_flush%0d", i), bus.ps_flush, 0);
      tick();
      chk($sformatf("idle_hold%0d", i), bus.ps_pm_add, 16'h0022);
    end
    clr_dcd();
    for (int i = 0; i < 13; i++) begin
      bus.ur_wrt_en = vt[i].wen; bus.ur_wrt_add = vt[i].wadd; bus.ur_wrt_dt = vt[i].wdt;
      bus.ur_rd_add = vt[i].radd;
      sb.push_back(32'(vt[i].exp));
      #1 chk($sformatf("ureg%0d", i), bus.ur_rd_dt, sb.pop_front());
      tick();
      bus.ur_wrt_en = 0;
    end
    chk("idle_still", bus.ps_idle, 1);
    bus.wake = 1;
    tick();
    bus.wake = 0;
    chk("wake_idle", bus.ps_idle, 0);
    chk("wake_cslt", bus.ps_pm_cslt, 1);
    chk("wake_pm_add", bus.ps_pm_add, 16'h0022);
    tick();
    chk("wake_pm_add_inc", bus.ps_pm_add, 16'h0023);
    sb.push_back(32'h22);
    pop_pc("wake_pc");
    issue("call30", 0, 1, 0, 16'h0030, 1, 16'h0030);
    pop_pc("call30_pc");
    chk("call30_cnt", bus.ps_stck_cnt, 1);
    bus.dcd_jmp = 1; bus.dcd_tgt = 16'h0077;
    #1 chk("mid_flush", bus.ps_flush, 1);
    rst = 0;
    #1 chk_reset("mid_rst");
    clr_dcd();
    #3 rst = 1;
    wait_ev();
    bus.dcd_idle = 1;
    tick();
    clr_dcd();
    chk("idle2_set", bus.ps_idle, 1);
    rst = 0;
    #1 chk_reset("idle_rst");
    #3 rst = 1;
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
